// File: rtl/wb_regfile.sv
// Write-back register file: a 2-deep retire buffer in front of a 32x32 array,
// with read ports that forward pending buffered writes.
module wb_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_valid_i,
    output logic        wb_ready_o,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        stall_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    output logic        busy_o
);

    logic        ent_we   [2];
    logic [4:0]  ent_addr [2];
    logic [31:0] ent_data [2];

    logic [1:0]  head;
    logic [1:0]  tail;
    logic [1:0]  count;
    logic [1:0]  head_nxt;
    logic [1:0]  tail_nxt;
    logic [1:0]  count_nxt;

    logic [31:0] regs [32];

    logic        accept;
    logic        retire;
    logic        head_sel;
    logic        tail_sel;
    logic        young_sel;
    logic        ret_write;

    assign head_sel  = (head == 2'd1);
    assign tail_sel  = (tail == 2'd1);
    // Youngest pending entry sits one slot behind the tail.
    assign young_sel = (tail == 2'd0);

    assign wb_ready_o = rst_ni && (count < 2'd2);
    assign busy_o     = (count != 2'd0);

    assign accept    = wb_valid_i && wb_ready_o;
    assign retire    = (count != 2'd0) && !stall_i;
    assign ret_write = retire && ent_we[head_sel] && (ent_addr[head_sel] != 5'd0);

    assign head_nxt = (head == 2'd1) ? 2'd0 : 2'd1;
    assign tail_nxt = (tail == 2'd1) ? 2'd0 : 2'd1;

    always_comb begin
        count_nxt = count;
        case ({accept, retire})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 2'd0;
        end else begin
            count <= count_nxt;
            if (accept) tail <= tail_nxt;
            if (retire) head <= head_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                ent_we[i]   <= 1'b0;
                ent_addr[i] <= 5'd0;
                ent_data[i] <= 32'd0;
            end
        end else if (accept) begin
            ent_we[tail_sel]   <= wb_we_i;
            ent_addr[tail_sel] <= wb_addr_i;
            ent_data[tail_sel] <= wb_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (ret_write) begin
            regs[ent_addr[head_sel]] <= ent_data[head_sel];
        end
    end

    // Forwarding order: x0 forced to zero, then youngest pending, then oldest, then array.
    function automatic logic [31:0] read_port(input logic [4:0] idx);
        logic [31:0] val;
        val = regs[idx];
        if ((count == 2'd2) && ent_we[head_sel] && (ent_addr[head_sel] == idx))
            val = ent_data[head_sel];
        if ((count != 2'd0) && ent_we[young_sel] && (ent_addr[young_sel] == idx))
            val = ent_data[young_sel];
        if (idx == 5'd0)
            val = 32'd0;
        return val;
    endfunction

    assign rdata_a_o = read_port(raddr_a_i);
    assign rdata_b_o = read_port(raddr_b_i);

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, stall back-pressure, ordering,
// x0 / we=0 handling and mid-operation reset.
module tb_wb_regfile;

    logic        clk_i;
    logic        rst_ni;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_wdata_i;
    logic        stall_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;
    logic [31:0] rdata_a_o;
    logic [31:0] rdata_b_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_regfile dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wb_valid_i (wb_valid_i),
        .wb_ready_o (wb_ready_o),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_wdata_i (wb_wdata_i),
        .stall_i    (stall_i),
        .raddr_a_i  (raddr_a_i),
        .raddr_b_i  (raddr_b_i),
        .rdata_a_o  (rdata_a_o),
        .rdata_b_o  (rdata_b_o),
        .busy_o     (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are then driven 2 time units after it.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_valid_i = v;
        wb_we_i    = we;
        wb_addr_i  = a;
        wb_wdata_i = d;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        raddr_a_i = a;
        raddr_b_i = b;
        #1;
    endtask

    initial begin
        rst_ni  = 1'b0;
        stall_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd5, 5'd1);
        #12;
        chk("rst_ready", {31'd0, wb_ready_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_rda",   rdata_a_o, 32'd0);

        // Basic write and bypass
        tick();
        rst_ni = 1'b1;
        #1;
        chk("rel_ready", {31'd0, wb_ready_o}, 32'd1);
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd0);
        chk("no_input_bypass", rdata_a_o, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd5, 5'd0);
        chk("b28_busy", {31'd0, busy_o}, 32'd1);
        chk("b28_bypass", rdata_a_o, 32'hDEADBEEF);
        tick();
        rd(5'd5, 5'd0);
        chk("b28_idle", {31'd0, busy_o}, 32'd0);
        chk("b28_array", rdata_a_o, 32'hDEADBEEF);
        chk("x0_read", rdata_b_o, 32'd0);

        // Stall with three back-to-back results
        stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd1, 32'h11);
        tick();
        drive(1'b1, 1'b1, 5'd2, 32'h22);
        tick();
        drive(1'b1, 1'b1, 5'd3, 32'h33);
        rd(5'd2, 5'd1);
        chk("full_ready", {31'd0, wb_ready_o}, 32'd0);
        chk("full_byp_x2", rdata_a_o, 32'h22);
        chk("full_byp_x1", rdata_b_o, 32'h11);
        tick();
        rd(5'd3, 5'd1);
        chk("held_ready", {31'd0, wb_ready_o}, 32'd0);
        chk("held_x3", rdata_a_o, 32'd0);
        chk("stalled_x1", rdata_b_o, 32'h11);
        stall_i = 1'b0;
        #1;
        chk("unstall_ready", {31'd0, wb_ready_o}, 32'd0);
        tick();
        rd(5'd1, 5'd2);
        chk("drain_ready", {31'd0, wb_ready_o}, 32'd1);
        chk("drain_busy", {31'd0, busy_o}, 32'd1);
        chk("drain_x1", rdata_a_o, 32'h11);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd3, 5'd2);
        chk("x3_bypass", rdata_a_o, 32'h33);
        tick();
        rd(5'd3, 5'd2);
        chk("b29_idle", {31'd0, busy_o}, 32'd0);
        chk("b29_x3", rdata_a_o, 32'h33);
        chk("b29_x2", rdata_b_o, 32'h22);
        rd(5'd1, 5'd5);
        chk("b29_x1", rdata_a_o, 32'h11);
        chk("x5_kept", rdata_b_o, 32'hDEADBEEF);

        // Same address twice: youngest wins
        stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 32'hA);
        tick();
        drive(1'b1, 1'b1, 5'd7, 32'hB);
        rd(5'd7, 5'd0);
        chk("x7_one_pending", rdata_a_o, 32'hA);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd7, 5'd0);
        chk("x7_youngest", rdata_a_o, 32'hB);
        tick();
        chk("stall_holds", {31'd0, busy_o}, 32'd1);
        stall_i = 1'b0;
        tick();
        rd(5'd7, 5'd0);
        chk("x7_mid_drain", rdata_a_o, 32'hB);
        tick();
        rd(5'd7, 5'd0);
        chk("b30_idle", {31'd0, busy_o}, 32'd0);
        chk("b30_x7", rdata_a_o, 32'hB);

        // x0 write and we=0 entry
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 1'b0, 5'd4, 32'h1234);
        rd(5'd0, 5'd4);
        chk("x0_pending", rdata_a_o, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd0, 5'd4);
        chk("x4_no_bypass", rdata_b_o, 32'd0);
        chk("b31_busy", {31'd0, busy_o}, 32'd1);
        tick();
        rd(5'd0, 5'd4);
        chk("b31_idle", {31'd0, busy_o}, 32'd0);
        chk("b31_x0", rdata_a_o, 32'd0);
        chk("b31_x4", rdata_b_o, 32'd0);

        // Reset with two entries pending
        stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd9, 32'h99);
        tick();
        drive(1'b1, 1'b1, 5'd10, 32'h1010);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd9, 5'd5);
        chk("pre_rst_x9", rdata_a_o, 32'h99);
        chk("pre_rst_full", {31'd0, wb_ready_o}, 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("async_ready", {31'd0, wb_ready_o}, 32'd0);
        chk("async_busy", {31'd0, busy_o}, 32'd0);
        chk("async_x9", rdata_a_o, 32'd0);
        chk("async_x5", rdata_b_o, 32'd0);
        tick();
        stall_i = 1'b0;
        rst_ni  = 1'b1;
        #1;
        chk("b33_ready", {31'd0, wb_ready_o}, 32'd1);
        tick();
        rd(5'd9, 5'd10);
        chk("b33_busy", {31'd0, busy_o}, 32'd0);
        chk("b33_x9", rdata_a_o, 32'd0);
        chk("b33_x10", rdata_b_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have no parameters; the buffer depth is 2, there are 32 registers and the data width is 32.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 wb_valid_i  input  1  ALU result valid this cycle.
REQ-005 wb_ready_o  output  1  block can accept a result this cycle.
REQ-006 wb_we_i  input  1  result requests a register write.
REQ-007 wb_addr_i  input  5  destination register index.
REQ-008 wb_wdata_i  input  32  result data.
REQ-009 stall_i  input  1  write port blocked; no retire this cycle.
REQ-010 raddr_a_i / raddr_b_i  input  5  read-port indices (rs1, rs2).
REQ-011 rdata_a_o / rdata_b_o  output  32  read-port data, combinational.
REQ-012 busy_o  output  1  buffer holds at least one pending entry.

Function
REQ-013 The block SHALL hold a 2-entry FIFO of {we, addr, wdata} plus a 32x32 register array.
- head pointer, tail pointer and count are 2 bits, with count in 0..2.
- The pointers wrap modulo 2.
REQ-014 wb_ready_o SHALL be 1 exactly when count < 2 and rst_ni = 1.
- It is decoded from the registered count and is independent of stall_i and of any retire in the same cycle.
REQ-015 An accept SHALL occur when wb_valid_i && wb_ready_o; the entry is written at the tail and the tail advances.
- wb_valid_i while wb_ready_o = 0 has no effect. The source must hold its data.
REQ-016 A retire SHALL occur when count > 0 && !stall_i; the head entry is consumed and the head advances.
REQ-017 On retire, the head SHALL write register[addr] = wdata only if we = 1 and addr != 0.
- Entries with we = 0, or with addr = 0, retire with no write.
REQ-018 Latency: a result accepted at edge N SHALL be written into the array at edge N+1 if stall_i is low in cycle N+1.
- Each cycle of stall_i delays the write by one cycle.
REQ-019 When accept and retire occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 Register 0 SHALL always read 0 and SHALL never be written.
REQ-021 Each read port SHALL return, in priority order:
- 0 if the index is 0;
- otherwise the youngest pending entry (tail-1 before head) with we = 1 and a matching addr;
- otherwise register[index].
REQ-022 Read bypass SHALL NOT include the wb_*_i inputs of the current cycle; only buffered entries are forwarded.
REQ-023 Two pending entries to the same addr SHALL retire in order, so the youngest value ends up in the array.
REQ-024 busy_o SHALL equal (count != 0).

Reset
REQ-025 While rst_ni = 0, the following SHALL hold immediately and asynchronously:
- count, head and tail = 0;
- all 32 registers = 0;
- wb_ready_o = 0 and busy_o = 0;
- rdata_a_o / rdata_b_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard pending entries; none of them reach the array.
REQ-027 In the first cycle after reset release, wb_ready_o SHALL be 1.

Verification
REQ-028 Reset release, then valid with we=1, addr=5, data=0xDEADBEEF and stall=0 -> accepted at edge N, busy_o=1; rdata_a_o(raddr 5)=0xDEADBEEF via bypass from cycle N; array holds the value after edge N+1; busy_o=0.
REQ-029 stall_i=1 with three back-to-back valids (addr 1,2,3; data 0x11,0x22,0x33) -> first two accepted, wb_ready_o=0 with count=2, third held; stall released -> all three written in order; reading x3 returns 0x33.
REQ-030 Two pending writes to addr 7 (0xA then 0xB) while stalled -> read of x7 returns 0xB; after the stall drops, the array ends at 0xB.
REQ-031 Writes to addr 0 with data 0xFFFFFFFF, and a we=0 entry to addr 4 -> x0 reads 0; x4 unchanged at 0; both entries retire.
REQ-032 Full buffer with stall_i=0 and valid high -> wb_ready_o=0 that cycle; the next cycle count=1, wb_ready_o=1 and the held entry is accepted.
REQ-033 rst_ni pulsed low with 2 entries pending (addr 9, 10) -> outputs drop at once; after release, x9=x10=0, busy_o=0 and wb_ready_o=1.
